// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA message scheduler and its FIFO.
package rsa_pkg;

  localparam int DATA_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ENC = 2'd2,
    HOLD     = 2'd3
  } sched_state_e;

  // Occupancy counter must be able to hold DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rsa_msg_fifo.sv
// Synchronous message FIFO; pointers wrap modulo DEPTH (power of two).
module rsa_msg_fifo
  import rsa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CW     = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              not_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign not_full = (count_q < CW'(DEPTH));
  assign push_ok  = push && not_full;
  assign pop_ok   = pop && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rsa_msg_scheduler.sv
// Buffers plaintext, feeds the rsa_encrypt core one message at a time, returns ciphertext.
// Optional saturating error counter output enabled by RSA_SCHED_ERRCNT_EN.
//
// state    | meaning
// IDLE     | waiting for key_done and a queued message
// ISSUE    | enc_m presented; range check against n
// WAIT_ENC | down-counting the encryption core latency
// HOLD     | result valid, waiting for c_ready
module rsa_msg_scheduler
  import rsa_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 4,
  parameter int ENC_LAT = 2,
  parameter int CW      = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_done,
  input  logic [DATA_W-1:0] n,
  input  logic [DATA_W-1:0] m_in,
  input  logic              m_valid,
  output logic              m_ready,
  output logic [DATA_W-1:0] enc_m,
  input  logic [DATA_W-1:0] enc_c,
  output logic [DATA_W-1:0] c_out,
  output logic              c_err,
  output logic              c_valid,
  input  logic              c_ready,
  output logic              busy,
  output logic [CW-1:0]     fifo_count
`ifdef RSA_SCHED_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int LW = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;

  sched_state_e      state_q, state_d;
  logic [DATA_W-1:0] enc_m_q, enc_m_d;
  logic [DATA_W-1:0] c_out_q, c_out_d;
  logic              c_err_q, c_err_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              pop;
  logic              push;
  logic              fifo_not_full;
  logic [DATA_W-1:0] fifo_head;

  assign push = m_valid && fifo_not_full;

  rsa_msg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (m_in),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .not_full  (fifo_not_full)
  );

  assign m_ready = fifo_not_full;
  assign enc_m   = enc_m_q;
  assign c_out   = c_out_q;
  assign c_err   = c_err_q;
  assign c_valid = (state_q == HOLD);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    enc_m_d = enc_m_q;
    c_out_d = c_out_q;
    c_err_d = c_err_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_done && (fifo_count != '0)) begin
          enc_m_d = fifo_head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Losing the key leaves the head queued so it is retried later.
        if (!key_done) begin
          state_d = IDLE;
        end else if ((enc_m_q >= n) || (n < DATA_W'(2))) begin
          c_out_d = '0;
          c_err_d = 1'b1;
          pop     = 1'b1;
          state_d = HOLD;
        end else begin
          lat_d   = LW'(ENC_LAT - 1);
          state_d = WAIT_ENC;
        end
      end
      WAIT_ENC: begin
        if (!key_done) begin
          state_d = IDLE;
        end else if (lat_q == '0) begin
          c_out_d = enc_c;
          c_err_d = 1'b0;
          pop     = 1'b1;
          state_d = HOLD;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      HOLD: begin
        if (c_ready) begin
          if (key_done && (fifo_count != '0)) begin
            enc_m_d = fifo_head;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      enc_m_q <= '0;
      c_out_q <= '0;
      c_err_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      enc_m_q <= enc_m_d;
      c_out_q <= c_out_d;
      c_err_q <= c_err_d;
      lat_q   <= lat_d;
    end
  end

`ifdef RSA_SCHED_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (c_valid && c_ready && c_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rsa_msg_scheduler.sv
// Self-checking bench for rsa_msg_scheduler with a pipelined encryption-core model (e=3).
module tb_rsa_msg_scheduler;

  localparam int DATA_W  = 7;
  localparam int DEPTH   = 4;
  localparam int ENC_LAT = 2;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              key_done;
  logic [DATA_W-1:0] n;
  logic [DATA_W-1:0] m_in;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] enc_m;
  logic [DATA_W-1:0] enc_c;
  logic [DATA_W-1:0] c_out;
  logic              c_err;
  logic              c_valid;
  logic              c_ready;
  logic              busy;
  logic [CW-1:0]     fifo_count;
`ifdef RSA_SCHED_ERRCNT_EN
  logic [7:0]        err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  rsa_msg_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ENC_LAT(ENC_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_done   (key_done),
    .n          (n),
    .m_in       (m_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .enc_m      (enc_m),
    .enc_c      (enc_c),
    .c_out      (c_out),
    .c_err      (c_err),
    .c_valid    (c_valid),
    .c_ready    (c_ready),
    .busy       (busy),
    .fifo_count (fifo_count)
`ifdef RSA_SCHED_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] modexp(input int m, input int e, input int nn);
    int r;
    if (nn == 0) return '0;
    r = 1 % nn;
    for (int i = 0; i < e; i++) r = (r * m) % nn;
    return DATA_W'(r);
  endfunction

  // Encryption core model: result of enc_m appears ENC_LAT cycles later.
  logic [DATA_W-1:0] enc_pipe [ENC_LAT];
  always @(posedge clk) begin
    enc_pipe[0] <= modexp(int'(enc_m), 3, int'(n));
    for (int i = 1; i < ENC_LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
  end
  assign enc_c = enc_pipe[ENC_LAT-1];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_msg(input logic [DATA_W-1:0] m, output bit ok);
    int w = 0;
    while (m_ready !== 1'b1 && w < 500) begin tick(); w++; end
    ok = (m_ready === 1'b1);
    if (ok) begin
      m_in = m; m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
    end
  endtask

  task automatic get_result(output logic [DATA_W-1:0] c, output logic e, output bit ok);
    int w = 0;
    while (c_valid !== 1'b1 && w < 200) begin tick(); w++; end
    ok = (c_valid === 1'b1);
    c = c_out; e = c_err;
    if (ok) begin
      c_ready = 1'b1;
      tick();
      c_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (c_valid !== 1'b0 || busy !== 1'b0 || m_ready !== 1'b1 || fifo_count !== '0 ||
        c_out !== '0 || c_err !== 1'b0 || enc_m !== '0) begin
      errors++;
      $display("FAIL reset_state: c_valid=%b busy=%b m_ready=%b count=%0d c_out=%0d c_err=%b enc_m=%0d required 0 0 1 0 0 0 0",
               c_valid, busy, m_ready, fifo_count, c_out, c_err, enc_m);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_key_gate();
    bit ok;
    n = 7'd55; key_done = 1'b0;
    push_msg(7'd53, ok);
    repeat (5) tick();
    checks++;
    if (fifo_count !== CW'(1) || busy !== 1'b0 || c_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_gate_hold: count=%0d busy=%b c_valid=%b required 1 0 0", fifo_count, busy, c_valid);
    end
    key_done = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (c_valid !== (k == 4)) begin
        errors++;
        $display("FAIL key_gate_latency: cycle %0d c_valid=%b required %b", k, c_valid, (k == 4));
      end
    end
    checks++;
    if (c_out !== 7'd47 || c_err !== 1'b0) begin
      errors++;
      $display("FAIL key_gate_result: c_out=%0d c_err=%b required 47 0", c_out, c_err);
    end
    c_ready = 1'b1; tick(); c_ready = 1'b0; tick();
    checks++;
    if (c_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL key_gate_drain: c_valid=%b busy=%b count=%0d required 0 0 0", c_valid, busy, fifo_count);
    end
  endtask

  task automatic test_range();
    bit ok;
    n = 7'd55; key_done = 1'b1;
    push_msg(7'd60, ok);
    push_msg(7'd55, ok);
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (busy !== 1'b1 || c_valid !== 1'b0) begin
        errors++;
        $display("FAIL range_issue%0d: busy=%b c_valid=%b required 1 0", r, busy, c_valid);
      end
      tick();
      checks++;
      if (c_valid !== 1'b1 || c_out !== '0 || c_err !== 1'b1 || fifo_count !== CW'(1 - r)) begin
        errors++;
        $display("FAIL range_result%0d: c_valid=%b c_out=%0d c_err=%b count=%0d required 1 0 1 %0d",
                 r, c_valid, c_out, c_err, fifo_count, 1 - r);
      end
      c_ready = 1'b1; tick(); c_ready = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL range_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DATA_W-1:0] c;
    logic e;
    logic [DATA_W-1:0] exp_c [5] = '{7'd8, 7'd27, 7'd9, 7'd15, 7'd51};
    n = 7'd55; key_done = 1'b1; c_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_msg(DATA_W'(i + 2), ok);
    checks++;
    if (m_ready !== 1'b0 || fifo_count !== CW'(4)) begin
      errors++;
      $display("FAIL bp_full: m_ready=%b count=%0d required 0 4", m_ready, fifo_count);
    end
    push_msg(7'd6, ok);
    checks++;
    if (!ok || m_ready !== 1'b0 || fifo_count !== CW'(4) || c_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_fifth: accepted=%b m_ready=%b count=%0d c_valid=%b required 1 0 4 1",
               ok, m_ready, fifo_count, c_valid);
    end
    for (int i = 0; i < 5; i++) begin
      get_result(c, e, ok);
      checks++;
      if (!ok || c !== exp_c[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL bp_result%0d: got=%0d err=%b seen=%b required %0d 0 1", i, c, e, ok, exp_c[i]);
      end
    end
    checks++;
    if (fifo_count !== '0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: count=%0d m_ready=%b required 0 1", fifo_count, m_ready);
    end
  endtask

  task automatic test_abort();
    bit ok;
    logic [DATA_W-1:0] c;
    logic e;
    int extra = 0;
    n = 7'd55; key_done = 1'b1; c_ready = 1'b0;
    push_msg(7'd53, ok);
    tick();
    tick();
    key_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || fifo_count !== CW'(1) || c_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b count=%0d c_valid=%b required 0 1 0", busy, fifo_count, c_valid);
    end
    repeat (3) tick();
    key_done = 1'b1;
    get_result(c, e, ok);
    checks++;
    if (!ok || c !== 7'd47 || e !== 1'b0) begin
      errors++;
      $display("FAIL abort_retry: got=%0d err=%b seen=%b required 47 0 1", c, e, ok);
    end
    for (int k = 0; k < 12; k++) begin
      if (c_valid === 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra != 0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL abort_once: extra_valid_cycles=%0d count=%0d required 0 0", extra, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    n = 7'd55; key_done = 1'b1; c_ready = 1'b0;
    push_msg(7'd3, ok);
    push_msg(7'd4, ok);
    tick();
    checks++;
    if (busy !== 1'b1 || fifo_count !== CW'(2)) begin
      errors++;
      $display("FAIL rstmid_setup: busy=%b count=%0d required 1 2", busy, fifo_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (c_valid !== 1'b0 || busy !== 1'b0 || m_ready !== 1'b1 || fifo_count !== '0 ||
        c_out !== '0 || c_err !== 1'b0 || enc_m !== '0) begin
      errors++;
      $display("FAIL rstmid_async: c_valid=%b busy=%b m_ready=%b count=%0d c_out=%0d c_err=%b enc_m=%0d required 0 0 1 0 0 0 0",
               c_valid, busy, m_ready, fifo_count, c_out, c_err, enc_m);
    end
    tick();
    reset = 1'b1;
    c_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (c_valid === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    c_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_discard: active_cycles=%0d required 0", seen);
    end
  endtask

`ifdef RSA_SCHED_ERRCNT_EN
  task automatic test_errcnt();
    bit ok;
    int w;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL errcnt_reset: err_cnt=%0d required 0", err_cnt);
    end
    n = 7'd55; key_done = 1'b1; c_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_msg(DATA_W'(100 + i), ok);
    w = 0;
    while ((busy === 1'b1 || fifo_count !== '0) && w < 200) begin tick(); w++; end
    checks++;
    if (err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL errcnt_three: err_cnt=%0d required 3", err_cnt);
    end
    for (int i = 0; i < 300; i++) push_msg(DATA_W'($urandom_range(55, 127)), ok);
    w = 0;
    while ((busy === 1'b1 || fifo_count !== '0) && w < 200) begin tick(); w++; end
    c_ready = 1'b0;
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL errcnt_sat: err_cnt=%0d required 255", err_cnt);
    end
  endtask
`endif

  task automatic test_random(input int batch);
    localparam int NMSG = 40;
    logic [DATA_W-1:0] exp_c_q [$];
    logic              exp_e_q [$];
    bit done = 0;
    case (batch)
      0:       n = DATA_W'($urandom_range(2, 127));
      1:       n = DATA_W'($urandom_range(60, 127));
      default: n = DATA_W'($urandom_range(0, 1));
    endcase
    key_done = 1'b1;
    fork
      begin : pusher
        bit ok;
        logic [DATA_W-1:0] m;
        for (int i = 0; i < NMSG; i++) begin
          m = DATA_W'($urandom_range(0, 127));
          push_msg(m, ok);
          if (ok) begin
            if (m >= n || n < 2) begin
              exp_c_q.push_back('0); exp_e_q.push_back(1'b1);
            end else begin
              exp_c_q.push_back(modexp(int'(m), 3, int'(n))); exp_e_q.push_back(1'b0);
            end
          end
          if ($urandom_range(0, 3) == 0) tick();
        end
      end
      begin : key_toggle
        while (!done) begin
          key_done = ($urandom_range(0, 9) != 0);
          tick();
        end
        key_done = 1'b1;
      end
      begin : collector
        int got = 0;
        int cyc = 0;
        logic [DATA_W-1:0] ec;
        logic ee;
        while (got < NMSG && cyc < 5000) begin
          c_ready = ($urandom_range(0, 1) == 1);
          if (c_valid === 1'b1 && c_ready) begin
            checks++;
            if (exp_c_q.size() == 0) begin
              errors++;
              $display("FAIL rand%0d_extra: c_out=%0d c_err=%b with no result pending", batch, c_out, c_err);
            end else begin
              ec = exp_c_q.pop_front();
              ee = exp_e_q.pop_front();
              if (c_out !== ec || c_err !== ee) begin
                errors++;
                $display("FAIL rand%0d_result%0d: c_out=%0d c_err=%b required %0d %b (n=%0d)",
                         batch, got, c_out, c_err, ec, ee, n);
              end
            end
            got++;
          end
          tick();
          cyc++;
        end
        c_ready = 1'b0;
        done = 1;
        checks++;
        if (got != NMSG) begin
          errors++;
          $display("FAIL rand%0d_timeout: results=%0d required %0d", batch, got, NMSG);
        end
      end
    join
    tick();
    checks++;
    if (busy !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL rand%0d_drain: busy=%b count=%0d required 0 0", batch, busy, fifo_count);
    end
  endtask

  initial begin
    reset = 1'b0; key_done = 1'b0; n = '0; m_in = '0; m_valid = 1'b0; c_ready = 1'b0;
    test_reset();
    test_key_gate();
    test_range();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef RSA_SCHED_ERRCNT_EN
    test_errcnt();
`endif
    for (int b = 0; b < 3; b++) test_random(b);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
